// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO hardware monitor.
package shared_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    STOPPED = 2'd3
  } monitor_state_e;

  // Bit positions in err_vec, one per independent check.
  localparam int ERR_FULL      = 0;
  localparam int ERR_EMPTY     = 1;
  localparam int ERR_AFULL     = 2;
  localparam int ERR_AEMPTY    = 3;
  localparam int ERR_WR_ACK    = 4;
  localparam int ERR_OVERFLOW  = 5;
  localparam int ERR_UNDERFLOW = 6;
  localparam int ERR_DATA_OUT  = 7;
  localparam int NUM_CHECKS    = 8;

endpackage

// File: rtl/fifo_ref_model.sv
// Shadow FIFO: storage, wrapping pointers and occupancy count that track
// what a correct FIFO should hold. Acceptance is decided from the count
// before the update, so wr+rd on empty is write-only and on full read-only.
module fifo_ref_model #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   upd_en,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       data_in,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head,
  output logic                   wr_accept,
  output logic                   rd_accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_do, rd_do;

  // Acceptance and next pointer/count; clear wins over any request.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    wr_accept = wr_en && (count_q != DEPTH_C);
    rd_accept = rd_en && (count_q != '0);
    wr_do     = upd_en && !clr && wr_accept;
    rd_do     = upd_en && !clr && rd_accept;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (upd_en && clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_do) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_do) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_do && !rd_do)      count_d = count_q + CW'(1);
      else if (rd_do && !wr_do) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; a word is only read after it has been written.
    if (wr_do) mem_q[wr_ptr_q] <= data_in;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_hw_monitor.sv
// Run-time checker for a synchronous FIFO: compares its flags and registered
// status against a shadow model and keeps sticky error bits and counters.
module fifo_hw_monitor
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  test_finished,
  input  logic                  fifo_rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic [1:0]            state,
  output logic                  mismatch,
  output logic [7:0]            err_vec,
  output logic [CNT_W-1:0]      error_count,
  output logic [CNT_W-1:0]      correct_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  monitor_state_e state_q, state_d;
  logic                  mismatch_q, mismatch_d;
  logic [NUM_CHECKS-1:0] err_vec_q, err_vec_d;
  logic [CNT_W-1:0]      error_count_q, error_count_d;
  logic [CNT_W-1:0]      correct_count_q, correct_count_d;
  // hold_q blanks the cycle after an observed-FIFO reset.
  logic                  hold_q, hold_d;
  // Expectations for the registered status, checked the cycle after the request.
  logic                  pend_valid_q, pend_valid_d;
  logic                  exp_wr_ack_q, exp_wr_ack_d;
  logic                  exp_ovf_q, exp_ovf_d;
  logic                  exp_unf_q, exp_unf_d;
  logic                  exp_rd_q, exp_rd_d;
  logic [FIFO_WIDTH-1:0] exp_data_q, exp_data_d;

  logic                  run, check_en, pend_chk, any_fail;
  logic [NUM_CHECKS-1:0] fail_vec;
  logic [CW-1:0]         model_count;
  logic [FIFO_WIDTH-1:0] model_head;
  logic                  model_wr_acc, model_rd_acc;

  assign run = (state_q == RUN);

  fifo_ref_model #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_model (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (run),
    .clr       (!fifo_rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .count     (model_count),
    .head      (model_head),
    .wr_accept (model_wr_acc),
    .rd_accept (model_rd_acc)
  );

  // Per-check comparison of observed signals against the model.
  always_comb begin
    check_en = run && fifo_rst_n && !hold_q;
    pend_chk = check_en && pend_valid_q;
    fail_vec = '0;
    fail_vec[ERR_FULL]      = check_en && (full        != (model_count == DEPTH_C));
    fail_vec[ERR_EMPTY]     = check_en && (empty       != (model_count == '0));
    fail_vec[ERR_AFULL]     = check_en && (almostfull  != (model_count == AFULL_C));
    fail_vec[ERR_AEMPTY]    = check_en && (almostempty != (model_count == ONE_C));
    fail_vec[ERR_WR_ACK]    = pend_chk && (wr_ack    != exp_wr_ack_q);
    fail_vec[ERR_OVERFLOW]  = pend_chk && (overflow  != exp_ovf_q);
    fail_vec[ERR_UNDERFLOW] = pend_chk && (underflow != exp_unf_q);
    fail_vec[ERR_DATA_OUT]  = pend_chk && exp_rd_q && (data_out != exp_data_q);
    any_fail = |fail_vec;
  end

  // Next-state: FSM, pending expectations, sticky errors and saturating counters.
  always_comb begin
    state_d         = state_q;
    hold_d          = run && !fifo_rst_n;
    pend_valid_d    = run && fifo_rst_n;
    exp_wr_ack_d    = model_wr_acc;
    exp_ovf_d       = wr_en && !model_wr_acc;
    exp_unf_d       = rd_en && !model_rd_acc;
    exp_rd_d        = model_rd_acc;
    exp_data_d      = model_head;
    mismatch_d      = any_fail;
    err_vec_d       = err_vec_q | fail_vec;
    error_count_d   = error_count_q;
    correct_count_d = correct_count_q;

    if (check_en) begin
      if (any_fail) begin
        if (error_count_q != CNT_MAX) error_count_d = error_count_q + CNT_W'(1);
      end else begin
        if (correct_count_q != CNT_MAX) correct_count_d = correct_count_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if ((STOP_ON_ERR != 0) && any_fail) state_d = STOPPED;
        else if (test_finished)            state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  // All monitor registers; DONE and STOPPED are left only through rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      mismatch_q      <= 1'b0;
      err_vec_q       <= '0;
      error_count_q   <= '0;
      correct_count_q <= '0;
      hold_q          <= 1'b0;
      pend_valid_q    <= 1'b0;
      exp_wr_ack_q    <= 1'b0;
      exp_ovf_q       <= 1'b0;
      exp_unf_q       <= 1'b0;
      exp_rd_q        <= 1'b0;
      exp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      mismatch_q      <= mismatch_d;
      err_vec_q       <= err_vec_d;
      error_count_q   <= error_count_d;
      correct_count_q <= correct_count_d;
      hold_q          <= hold_d;
      pend_valid_q    <= pend_valid_d;
      exp_wr_ack_q    <= exp_wr_ack_d;
      exp_ovf_q       <= exp_ovf_d;
      exp_unf_q       <= exp_unf_d;
      exp_rd_q        <= exp_rd_d;
      exp_data_q      <= exp_data_d;
    end
  end

  assign state         = state_q;
  assign mismatch      = mismatch_q;
  assign err_vec       = err_vec_q;
  assign error_count   = error_count_q;
  assign correct_count = correct_count_q;

endmodule
